// File: rtl/wb8_decoder.sv
// wb8_decoder
//   8-bit Wishbone address decoder with a bus watchdog. The master port is
//   routed combinationally to the lowest-indexed slave whose base/mask window
//   matches ADR_I. If no window matches, DEFAULT_SLAVE is used. A watchdog
//   counts unacknowledged strobe cycles. After TIMEOUT of them it spends one
//   ABORT cycle that acknowledges the master with TIMEOUT_DATA and records
//   the faulting address and a saturating fault count.
//
// Ports
//   CLK_I, RST_I        clock, synchronous active-high reset
//   ADR_I, STB_I, WE_I  master address / strobe / write enable (WE_I unused)
//   DAT_O, ACK_O        read data and acknowledge to the master
//   STALL_O             stall to the master
//   SLV_STB_O           one-hot slave strobes
//   SLV_DAT_I           packed slave read data, 8 bits per slave
//   SLV_ACK_I           slave acknowledges
//   SLV_STALL_I         slave stalls
//   CLR_FAULT_I         clears FAULT_CNT_O
//   TIMEOUT_O           one-cycle pulse during an abort
//   FAULT_ADR_O         address of the most recent aborted cycle
//   FAULT_CNT_O         abort count, saturating at 255
module wb8_decoder #(
    parameter int unsigned           NSLAVES       = 8,
    parameter logic [NSLAVES*32-1:0] BASES         = '0,
    parameter logic [NSLAVES*32-1:0] MASKS         = '0,
    parameter int unsigned           DEFAULT_SLAVE = NSLAVES - 1,
    parameter int unsigned           TIMEOUT       = 255,
    parameter logic [7:0]            TIMEOUT_DATA  = 8'hFF
) (
    input  logic                   CLK_I,
    input  logic                   RST_I,
    input  logic [31:0]            ADR_I,
    input  logic                   STB_I,
    input  logic                   WE_I,
    output logic [7:0]             DAT_O,
    output logic                   ACK_O,
    output logic                   STALL_O,
    output logic [NSLAVES-1:0]     SLV_STB_O,
    input  logic [NSLAVES*8-1:0]   SLV_DAT_I,
    input  logic [NSLAVES-1:0]     SLV_ACK_I,
    input  logic [NSLAVES-1:0]     SLV_STALL_I,
    input  logic                   CLR_FAULT_I,
    output logic                   TIMEOUT_O,
    output logic [31:0]            FAULT_ADR_O,
    output logic [7:0]             FAULT_CNT_O
);

    localparam int unsigned SW    = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
    localparam bit          WD_ON = (TIMEOUT != 0);
    localparam logic [15:0] LAST  = 16'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ABORT
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [15:0]   cnt;
    logic [15:0]   cnt_next;
    logic [SW-1:0] sel;
    logic          found;
    logic          sel_ack;
    logic          sel_stall;
    logic [31:0]   fault_adr;
    logic [7:0]    fault_cnt;
    logic          unused_we;

    // WE_I is passed to the slaves on a separate path; it is not decoded here.
    assign unused_we = WE_I;

    // Address decode: the lowest matching index wins.
    always_comb begin
        found = 1'b0;
        sel   = SW'(DEFAULT_SLAVE);
        for (int unsigned i = 0; i < NSLAVES; i++) begin
            if (!found &&
                ((ADR_I & MASKS[32*i +: 32]) == (BASES[32*i +: 32] & MASKS[32*i +: 32]))) begin
                found = 1'b1;
                sel   = SW'(i);
            end
        end
    end

    assign sel_ack   = SLV_ACK_I[sel];
    assign sel_stall = SLV_STALL_I[sel];

    // Watchdog next state and master/slave routing
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        SLV_STB_O  = '0;
        ACK_O      = 1'b0;
        STALL_O    = 1'b0;
        TIMEOUT_O  = 1'b0;
        DAT_O      = SLV_DAT_I[{sel, 3'b000} +: 8];

        if (!RST_I) begin
            if (state == ST_ABORT) begin
                // The abort cycle owns the bus; late slave acks are ignored.
                ACK_O      = 1'b1;
                DAT_O      = TIMEOUT_DATA;
                TIMEOUT_O  = 1'b1;
                state_next = ST_IDLE;
                cnt_next   = '0;
            end else begin
                SLV_STB_O[sel] = STB_I;
                ACK_O          = sel_ack;
                STALL_O        = sel_stall;

                if (state == ST_IDLE) begin
                    cnt_next = '0;
                    if (WD_ON && STB_I && !sel_ack) begin
                        // With a one-cycle timeout the first unacked cycle aborts.
                        if (TIMEOUT == 1) begin
                            state_next = ST_ABORT;
                        end else begin
                            state_next = ST_WAIT;
                            cnt_next   = 16'd1;
                        end
                    end
                end else begin
                    if (sel_ack || !STB_I) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end else if (cnt == LAST) begin
                        state_next = ST_ABORT;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 16'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Fault record. An abort takes priority over a clear in the same cycle.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            fault_adr <= '0;
            fault_cnt <= '0;
        end else if (state == ST_ABORT) begin
            fault_adr <= ADR_I;
            if (CLR_FAULT_I) begin
                fault_cnt <= 8'd1;
            end else if (fault_cnt != 8'hFF) begin
                fault_cnt <= fault_cnt + 8'd1;
            end
        end else if (CLR_FAULT_I) begin
            fault_cnt <= '0;
        end
    end

    assign FAULT_ADR_O = fault_adr;
    assign FAULT_CNT_O = fault_cnt;

endmodule

// File: tb/tb_wb8_decoder.sv
module tb_wb8_decoder;

    localparam int NS = 4;
    localparam int TO = 4;

    // Windows expressed as address ranges (lowest index has priority).
    localparam logic [31:0] LO [NS] = '{32'hFFFFF800, 32'hFFFFF800, 32'h00010000, 32'h20000000};
    localparam logic [31:0] HI [NS] = '{32'hFFFFF8FF, 32'hFFFFFFFF, 32'h0001FFFF, 32'h2FFFFFFF};
    localparam logic [31:0] ADRS [6] = '{32'hFFFFF800, 32'hFFFFFA10, 32'h00010044,
                                         32'h00001234, 32'h2ABCDEF0, 32'hFFFFF8C3};

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   adr;
    logic          stb;
    logic          we;
    logic [7:0]    dat;
    logic          ack;
    logic          stall;
    logic [NS-1:0] slv_stb;
    logic [NS*8-1:0] slv_dat;
    logic [NS-1:0] slv_ack;
    logic [NS-1:0] slv_stall;
    logic          clr;
    logic          tmo;
    logic [31:0]   fadr;
    logic [7:0]    fcnt;

    int passed = 0;
    int total  = 0;

    // Reference model state
    int          pend;
    logic [31:0] m_fadr;
    int          m_fcnt;

    always #5 clk = ~clk;

    wb8_decoder #(
        .NSLAVES      (NS),
        .BASES        ({32'h20000000, 32'h00010000, 32'hFFFFF800, 32'hFFFFF800}),
        .MASKS        ({32'hF0000000, 32'hFFFF0000, 32'hFFFFF800, 32'hFFFFFF00}),
        .DEFAULT_SLAVE(3),
        .TIMEOUT      (TO),
        .TIMEOUT_DATA (8'hFF)
    ) dut (
        .CLK_I      (clk),
        .RST_I      (rst),
        .ADR_I      (adr),
        .STB_I      (stb),
        .WE_I       (we),
        .DAT_O      (dat),
        .ACK_O      (ack),
        .STALL_O    (stall),
        .SLV_STB_O  (slv_stb),
        .SLV_DAT_I  (slv_dat),
        .SLV_ACK_I  (slv_ack),
        .SLV_STALL_I(slv_stall),
        .CLR_FAULT_I(clr),
        .TIMEOUT_O  (tmo),
        .FAULT_ADR_O(fadr),
        .FAULT_CNT_O(fcnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        else
            passed++;
    endtask

    function automatic int dec(input logic [31:0] a);
        for (int i = 0; i < NS; i++)
            if (a >= LO[i] && a <= HI[i]) return i;
        return 3;
    endfunction

    // Settle inputs, then compare every output against the model.
    task automatic apply();
        int         s;
        logic [3:0] oh;
        #1;
        s  = dec(adr);
        oh = '0;
        if (stb) oh[s] = 1'b1;
        if (rst) begin
            chk("m_rst_stb", slv_stb, 0);
            chk("m_rst_ack", ack, 0);
            chk("m_rst_stall", stall, 0);
            chk("m_rst_tmo", tmo, 0);
        end else if (pend == TO) begin
            chk("m_abort_stb", slv_stb, 0);
            chk("m_abort_ack", ack, 1);
            chk("m_abort_dat", dat, 8'hFF);
            chk("m_abort_stall", stall, 0);
            chk("m_abort_tmo", tmo, 1);
        end else begin
            chk("m_stb", slv_stb, oh);
            chk("m_ack", ack, slv_ack[s]);
            chk("m_dat", dat, slv_dat[8*s +: 8]);
            chk("m_stall", stall, slv_stall[s]);
            chk("m_tmo", tmo, 0);
        end
        chk("m_fadr", fadr, m_fadr);
        chk("m_fcnt", fcnt, m_fcnt);
    endtask

    // Advance one clock and update the model with the sampled inputs.
    task automatic clock();
        @(posedge clk);
        if (rst) begin
            pend = 0; m_fadr = '0; m_fcnt = 0;
        end else if (pend == TO) begin
            m_fadr = adr;
            m_fcnt = clr ? 1 : (m_fcnt < 255 ? m_fcnt + 1 : 255);
            pend   = 0;
        end else begin
            if (clr) m_fcnt = 0;
            pend = (stb && !slv_ack[dec(adr)]) ? pend + 1 : 0;
        end
        @(negedge clk);
    endtask

    task automatic cyc();
        apply();
        clock();
    endtask

    typedef struct {
        logic [31:0] adr;
        logic        stb;
        logic [3:0]  sack;
        logic [3:0]  sstall;
        logic [3:0]  e_stb;
        logic        e_ack;
        logic        e_stall;
        logic [7:0]  e_dat;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{32'hFFFFF800, 1'b1, 4'hF, 4'h0, 4'b0001, 1'b1, 1'b0, 8'h10};
        tbl[1] = '{32'h00001234, 1'b1, 4'hF, 4'h0, 4'b1000, 1'b1, 1'b0, 8'h3C};
        tbl[2] = '{32'h00010044, 1'b1, 4'b0100, 4'h0, 4'b0100, 1'b1, 1'b0, 8'hA5};
        tbl[3] = '{32'hFFFFFA10, 1'b1, 4'b0010, 4'h0, 4'b0010, 1'b1, 1'b0, 8'h21};
        tbl[4] = '{32'h20000000, 1'b1, 4'b1000, 4'h0, 4'b1000, 1'b1, 1'b0, 8'h3C};
        tbl[5] = '{32'hFFFFF800, 1'b0, 4'h0, 4'h0, 4'b0000, 1'b0, 1'b0, 8'h10};
        tbl[6] = '{32'hFFFFF8FF, 1'b1, 4'b0001, 4'b1110, 4'b0001, 1'b1, 1'b0, 8'h10};
        tbl[7] = '{32'h00010000, 1'b1, 4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1, 8'hA5};

        pend = 0; m_fadr = '0; m_fcnt = 0;
        rst = 1'b1; adr = 32'hFFFFF800; stb = 1'b1; we = 1'b0; clr = 1'b0;
        slv_ack = '0; slv_stall = '0; slv_dat = {8'h3C, 8'hA5, 8'h21, 8'h10};
        @(negedge clk);

        // Reset: strobes/acks blocked even with STB_I high
        apply();
        chk("rst_slv_stb", slv_stb, 0);
        chk("rst_ack", ack, 0);
        clock();
        cyc();
        rst = 1'b0; stb = 1'b0;
        apply();
        chk("rst_fcnt", fcnt, 0);
        chk("rst_fadr", fadr, 0);
        chk("rst_tmo", tmo, 0);
        clock();

        // Decode/routing table
        for (int i = 0; i < 8; i++) begin
            adr = tbl[i].adr; stb = tbl[i].stb;
            slv_ack = tbl[i].sack; slv_stall = tbl[i].sstall;
            apply();
            chk($sformatf("tbl%0d_stb", i), slv_stb, tbl[i].e_stb);
            chk($sformatf("tbl%0d_ack", i), ack, tbl[i].e_ack);
            chk($sformatf("tbl%0d_stall", i), stall, tbl[i].e_stall);
            chk($sformatf("tbl%0d_dat", i), dat, tbl[i].e_dat);
            chk($sformatf("tbl%0d_tmo", i), tmo, 0);
            clock();
        end
        stb = 1'b0; slv_ack = '0; slv_stall = '0;
        cyc();

        // Timeout with stalled slave; late ack in the abort cycle is ignored
        adr = 32'hFFFFFA10; stb = 1'b1;
        for (int c = 0; c < TO; c++) begin
            slv_stall = 4'b0010;
            apply();
            chk("to_wait_ack", ack, 0);
            chk("to_wait_tmo", tmo, 0);
            chk("to_wait_stb", slv_stb, 4'b0010);
            chk("to_wait_stall", stall, 1);
            clock();
        end
        slv_ack = 4'b1111;
        apply();
        chk("to_abort_ack", ack, 1);
        chk("to_abort_tmo", tmo, 1);
        chk("to_abort_dat", dat, 8'hFF);
        chk("to_abort_stb", slv_stb, 0);
        chk("to_abort_stall", stall, 0);
        clock();
        stb = 1'b0; slv_ack = '0; slv_stall = '0;
        apply();
        chk("to_after_ack", ack, 0);
        chk("to_after_tmo", tmo, 0);
        chk("to_fadr", fadr, 32'hFFFFFA10);
        chk("to_fcnt", fcnt, 1);
        clock();

        // Near miss: ack in cycle TO-1
        stb = 1'b1;
        for (int c = 0; c < TO - 1; c++) cyc();
        slv_ack = 4'b0010;
        apply();
        chk("nm_ack", ack, 1);
        chk("nm_dat", dat, 8'h21);
        chk("nm_tmo", tmo, 0);
        clock();
        stb = 1'b0; slv_ack = '0;
        apply();
        chk("nm_tmo_after", tmo, 0);
        chk("nm_fcnt", fcnt, 1);
        clock();

        // 300 back-to-back aborts with STB_I held high
        stb = 1'b1;
        for (int n = 0; n < 300; n++) begin
            for (int c = 0; c < TO; c++) cyc();
            apply();
            if (n == 299) chk("sat_abort_tmo", tmo, 1);
            clock();
        end
        stb = 1'b0;
        apply();
        chk("sat_fcnt", fcnt, 255);
        clock();

        // Clear coinciding with abort
        stb = 1'b1;
        for (int c = 0; c < TO; c++) cyc();
        clr = 1'b1;
        apply();
        chk("clr_abort_tmo", tmo, 1);
        clock();
        clr = 1'b0; stb = 1'b0;
        apply();
        chk("clr_abort_fcnt", fcnt, 1);
        clock();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        apply();
        chk("clr_fcnt", fcnt, 0);
        chk("clr_fadr_kept", fadr, 32'hFFFFFA10);
        clock();

        // Reset in WAIT at cnt=2, then a full timeout again
        adr = 32'hFFFFF804; stb = 1'b1;
        cyc();
        cyc();
        rst = 1'b1;
        apply();
        chk("rmid_stb", slv_stb, 0);
        chk("rmid_ack", ack, 0);
        clock();
        rst = 1'b0; stb = 1'b0;
        apply();
        chk("rmid_slv_stb", slv_stb, 0);
        chk("rmid_fcnt", fcnt, 0);
        chk("rmid_fadr", fadr, 0);
        chk("rmid_tmo", tmo, 0);
        clock();
        stb = 1'b1;
        for (int c = 0; c < TO; c++) begin
            apply();
            chk("rmid_wait_ack", ack, 0);
            clock();
        end
        apply();
        chk("rmid_abort_ack", ack, 1);
        chk("rmid_abort_tmo", tmo, 1);
        clock();
        stb = 1'b0;
        apply();
        chk("rmid_abort_fadr", fadr, 32'hFFFFF804);
        clock();

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            adr       = ADRS[$urandom_range(0, 5)];
            stb       = ($urandom_range(0, 3) != 0);
            we        = 1'($urandom);
            slv_ack   = 4'($urandom) & 4'($urandom);
            slv_stall = 4'($urandom);
            slv_dat   = 32'($urandom);
            clr       = ($urandom_range(0, 19) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/wb8_decoder.md
# wb8_decoder

Parametrised 8-bit Wishbone address decoder and bus watchdog. It sits between the CPU master port and N slave peripherals, and it replaces the hand-written per-board `casez` arbiter. Slave windows are described by base/mask parameter vectors. A watchdog terminates any cycle that a slave never acknowledges, returns a fixed error byte, and records the fault so software can inspect it.

## Interface
Parameters:
- NSLAVES, 8: number of slave channels (1..16).
- BASES, all zero: NSLAVES×32-bit packed vector; slave i occupies bits [32i+31:32i].
- MASKS, all zero: NSLAVES×32-bit packed vector; a 1 bit means the address bit is compared.
- DEFAULT_SLAVE, NSLAVES-1: channel selected when no window matches.
- TIMEOUT, 255: cycles without acknowledge before abort (0..65535); 0 disables the watchdog.
- TIMEOUT_DATA, 8'hFF: byte returned on an aborted read.

Ports:
- CLK_I  in  1  system clock.
- RST_I  in  1  synchronous, active-high reset.
- ADR_I  in  32  master address, held stable while STB_I is high.
- STB_I  in  1  master strobe.
- WE_I  in  1  master write enable; pass-through only, not decoded.
- DAT_O  out  8  read data to master.
- ACK_O  out  1  acknowledge to master.
- STALL_O  out  1  stall to master.
- SLV_STB_O  out  NSLAVES  one-hot slave strobes.
- SLV_DAT_I  in  NSLAVES×8  packed slave read data.
- SLV_ACK_I  in  NSLAVES  slave acknowledges.
- SLV_STALL_I  in  NSLAVES  slave stalls.
- CLR_FAULT_I  in  1  one-cycle pulse that clears the fault counter.
- TIMEOUT_O  out  1  one-cycle pulse on abort.
- FAULT_ADR_O  out  32  address of the most recent aborted cycle.
- FAULT_CNT_O  out  8  number of aborts, saturating at 255.

## Operation
- Decode (combinational):
  - Slave i matches when (ADR_I & MASK_i) == (BASE_i & MASK_i).
  - Lowest matching index wins.
  - No match selects DEFAULT_SLAVE.
- Routing:
  - SLV_STB_O[sel] = STB_I; all other strobes are 0.
  - DAT_O = SLV_DAT_I[sel], ACK_O = SLV_ACK_I[sel], STALL_O = SLV_STALL_I[sel].
  - Zero added latency, identical to the old arbiter.
- State machine (watchdog):
  - IDLE: cnt=0. On STB_I=1 with no ACK_O: cnt<=1, go to WAIT.
  - WAIT: counts cycles while STB_I stays high and the selected slave does not acknowledge.
    - Selected ACK, or STB_I dropping, → IDLE, cnt<=0.
    - Stalled cycles count toward the timeout.
    - cnt==TIMEOUT-1 with no ACK → ABORT.
  - ABORT: lasts exactly one cycle, then IDLE.
    - ACK_O=1, DAT_O=TIMEOUT_DATA, STALL_O=0, all SLV_STB_O=0.
    - Any SLV_ACK_I arriving in this cycle is ignored.
    - TIMEOUT_O=1, FAULT_ADR_O<=ADR_I, FAULT_CNT_O<=FAULT_CNT_O+1, saturating at 255.
- A write that times out is treated the same as a read: it is acknowledged and its data is discarded.
- TIMEOUT=1: ABORT follows the first unacknowledged cycle.
- TIMEOUT=0: the FSM stays in IDLE and the fault outputs stay at reset values.
- CLR_FAULT_I:
  - Sets FAULT_CNT_O<=0; FAULT_ADR_O is kept.
  - If it coincides with ABORT, the abort wins and FAULT_CNT_O<=1.
- cnt is 16 bits and cannot wrap, because ABORT is entered first.

## Timing
- Reset (RST_I=1 at a clock edge):
  - State IDLE, cnt=0, TIMEOUT_O=0, FAULT_ADR_O=0, FAULT_CNT_O=0.
  - While RST_I is high, SLV_STB_O=0, ACK_O=0 and STALL_O=0, regardless of STB_I.
  - Reset in WAIT or ABORT abandons the cycle without a fault record.
- Normal access: ACK_O is valid in the same cycle as the slave ACK. Single-cycle slaves see no penalty.
- Abort timing: STB_I rises in cycle 0 and no ACK follows.
  - Cycles 0..TIMEOUT-1 are in IDLE/WAIT.
  - Cycle TIMEOUT is ABORT, with ACK_O=1.
  - Cycle TIMEOUT+1 is IDLE. If the master has already issued a new STB_I, it is decoded normally.
- Back-to-back strobes: an ACK in cycle n clears cnt. A new STB_I in cycle n+1 starts a fresh count at 1.
- TIMEOUT_O is high for exactly one cycle per abort.

## Test plan
- Decode priority: BASES/MASKS make slaves 0 and 1 both match 0xFFFFF800. Read 0xFFFFF800 → only SLV_STB_O[0]=1 and DAT_O = slave 0 data. Read 0x00001234 (no window matches) → DEFAULT_SLAVE strobed.
- Zero-latency pass-through: slave 2 acks in the same cycle with 8'hA5 → ACK_O=1 and DAT_O=8'hA5 in that cycle; watchdog state stays IDLE.
- Timeout: TIMEOUT=4, slave never acks, read 0xFFFFFA10.
  - ACK_O and TIMEOUT_O rise in cycle 4 with DAT_O=8'hFF and SLV_STB_O=0.
  - After that cycle, FAULT_ADR_O=0xFFFFFA10 and FAULT_CNT_O=1.
- Near miss: TIMEOUT=4, slave acks in cycle 3 → normal ACK in cycle 3, no TIMEOUT_O, FAULT_CNT_O unchanged. A slave ack arriving in the ABORT cycle is ignored and produces no second ACK_O.
- Counter: force 300 aborts → FAULT_CNT_O saturates at 255. Assert CLR_FAULT_I in the same cycle as an abort → FAULT_CNT_O=1.
- Reset mid-cycle: assert RST_I in WAIT at cnt=2 → next cycle IDLE, all strobes 0, fault outputs 0. Deassert RST_I and repeat the read → full TIMEOUT cycles elapse before abort.
